// File: rtl/pipe_ctrl.sv
// Pipeline stall and multi-cycle EX sequencing controller for the five-stage core.
// Merges ID/MEM/EX stall requests into a per-stage stall vector and keeps a saturating stall-cycle count.
module pipe_ctrl #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id_i,
  input  logic              stallreq_mem_i,
  input  logic              mc_start_i,
  input  logic [CNT_W-1:0]  mc_cycles_i,
  input  logic              mc_cancel_i,
  output logic [5:0]        stall_o,
  output logic              mc_busy_o,
  output logic              mc_done_o,
  output logic [CNT_W-1:0]  mc_cnt_o,
  output logic [PERF_W-1:0] perf_stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   op_len;
  logic               ex_stall;
  logic [PERF_W-1:0]  perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A requested length of zero is executed as a single-cycle operation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_len  = (mc_cycles_i == '0) ? CNT_W'(1) : mc_cycles_i;
    case (state_q)
      IDLE: begin
        if (mc_start_i && !mc_cancel_i) begin
          cnt_d   = op_len - CNT_W'(1);
          state_d = (op_len == CNT_W'(1)) ? DONE : RUN;
        end else if (mc_start_i) begin
          cnt_d = '0;
        end
      end
      RUN: begin
        if (mc_cancel_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // MEM outranks EX, which outranks ID; reset forces the vector clear.
  always_comb begin
    ex_stall  = ((state_q == IDLE) && mc_start_i && !mc_cancel_i) ||
                ((state_q == RUN) && !mc_cancel_i);
    mc_busy_o = (state_q == RUN);
    mc_done_o = (state_q == DONE);
    mc_cnt_o  = cnt_q;
    if (rst) begin
      stall_o = 6'b000000;
    end else if (stallreq_mem_i) begin
      stall_o = 6'b011111;
    end else if (ex_stall) begin
      stall_o = 6'b001111;
    end else if (stallreq_id_i) begin
      stall_o = 6'b000111;
    end else begin
      stall_o = 6'b000000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if ((stall_o != 6'b000000) && (perf_q != '1)) begin
      perf_q <= perf_q + PERF_W'(1);
    end
  end

  assign perf_stall_cnt_o = perf_q;

endmodule
